// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates from Rename, records out-of-order completions,
// retires the oldest completed entry per cycle into the RRAT, free list and LSQ.
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic             FLUSH,
    input  logic             alloc_valid,
    input  logic [88:0]      alloc_entry,
    input  logic [4:0]       alloc_arch_dst,
    output logic [IDX_W-1:0] alloc_idx,
    output logic             rob_halt,
    input  logic             cmpl_valid,
    input  logic [IDX_W-1:0] cmpl_idx,
    input  logic [5:0]       rrat_old_phys,
    output logic             rrat_wr_en,
    output logic [4:0]       rrat_arch,
    output logic [5:0]       rrat_phys,
    output logic             rob_free,
    output logic [5:0]       rob_free_reg,
    output logic             st_commit,
    output logic [31:0]      retire_count,
    output logic             err_overflow
);
    localparam logic [IDX_W:0]   FULL_N  = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   HALT_N  = (IDX_W+1)'(DEPTH - 1);
    localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic [IDX_W-1:0] head, tail;
    logic [IDX_W:0]   count;
    logic [DEPTH-1:0] valid, done;
    logic [88:0]      entry_mem [DEPTH];
    logic [4:0]       arch_mem  [DEPTH];

    logic        full, do_alloc, do_retire, head_wr;
    logic [88:0] head_entry;

    always_comb begin
        full       = (count == FULL_N);
        head_entry = entry_mem[head];
        // control[5]=reg-write, control[4]=load; both update the RRAT
        head_wr    = head_entry[23] | head_entry[22];
        do_alloc   = alloc_valid & ~STALL & ~full & ~FLUSH;
        do_retire  = valid[head] & done[head] & ~STALL & ~FLUSH;
    end

    assign alloc_idx = tail;
    assign rob_halt  = (count >= HALT_N);

    // Payload storage needs no reset: valid bits gate every use of it.
    always_ff @(posedge CLK) begin
        if (!RESET && do_alloc) begin
            entry_mem[tail] <= alloc_entry;
            arch_mem[tail]  <= alloc_arch_dst;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            valid        <= '0;
            done         <= '0;
            rrat_wr_en   <= 1'b0;
            rrat_arch    <= '0;
            rrat_phys    <= '0;
            rob_free     <= 1'b0;
            rob_free_reg <= '0;
            st_commit    <= 1'b0;
            retire_count <= '0;
            err_overflow <= 1'b0;
        end else begin
            rrat_wr_en <= 1'b0;
            rob_free   <= 1'b0;
            st_commit  <= 1'b0;
            if (FLUSH) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                valid <= '0;
                done  <= '0;
            end else begin
                if (alloc_valid && full)
                    err_overflow <= 1'b1;
                if (cmpl_valid && valid[cmpl_idx])
                    done[cmpl_idx] <= 1'b1;
                if (do_alloc) begin
                    valid[tail] <= 1'b1;
                    done[tail]  <= 1'b0;
                    tail        <= tail + IDX_ONE;
                end
                if (do_retire) begin
                    valid[head]  <= 1'b0;
                    head         <= head + IDX_ONE;
                    rrat_wr_en   <= head_wr;
                    rrat_arch    <= arch_mem[head];
                    rrat_phys    <= head_entry[17:12];
                    // physical register 0 is never handed back to the free list
                    rob_free     <= head_wr & (rrat_old_phys != 6'd0);
                    rob_free_reg <= rrat_old_phys;
                    st_commit    <= head_entry[21];
                    retire_count <= retire_count + 32'd1;
                end
                case ({do_alloc, do_retire})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reorder_buffer;
    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    logic CLK = 1'b0;
    logic RESET, STALL, FLUSH, alloc_valid, cmpl_valid;
    logic [88:0] alloc_entry;
    logic [4:0]  alloc_arch_dst;
    logic [IDX_W-1:0] alloc_idx, cmpl_idx;
    logic rob_halt, rrat_wr_en, rob_free, st_commit, err_overflow;
    logic [5:0] rrat_old_phys, rrat_phys, rob_free_reg;
    logic [4:0] rrat_arch;
    logic [31:0] retire_count;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 CLK = ~CLK;

    reorder_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
        .alloc_valid(alloc_valid), .alloc_entry(alloc_entry), .alloc_arch_dst(alloc_arch_dst),
        .alloc_idx(alloc_idx), .rob_halt(rob_halt),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx), .rrat_old_phys(rrat_old_phys),
        .rrat_wr_en(rrat_wr_en), .rrat_arch(rrat_arch), .rrat_phys(rrat_phys),
        .rob_free(rob_free), .rob_free_reg(rob_free_reg), .st_commit(st_commit),
        .retire_count(retire_count), .err_overflow(err_overflow)
    );

    // Reference model: program order is the queue of occupied slot numbers.
    int          q[$];
    logic [88:0] m_entry [DEPTH];
    logic [4:0]  m_arch  [DEPTH];
    bit          m_done  [DEPTH];
    int          m_tail;
    logic        e_wr, e_free, e_st, e_err;
    logic [4:0]  e_arch;
    logic [5:0]  e_phys, e_free_reg;
    logic [31:0] e_count;
    logic [5:0]  phys_log[$];

    always @(posedge CLK) begin
        if (RESET) begin
            q.delete(); m_tail = 0;
            for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
            e_wr = 0; e_free = 0; e_st = 0; e_err = 0;
            e_arch = 0; e_phys = 0; e_free_reg = 0; e_count = 0;
        end else begin
            e_wr = 0; e_free = 0; e_st = 0;
            if (FLUSH) begin
                q.delete(); m_tail = 0;
            end else begin
                automatic bit full   = (q.size() == DEPTH);
                automatic bit retire = (q.size() > 0) && m_done[q[0]] && !STALL;
                automatic bit alloc  = alloc_valid && !STALL && !full;
                automatic bit in_q   = 1'b0;
                foreach (q[k]) if (q[k] == int'(cmpl_idx)) in_q = 1'b1;
                if (alloc_valid && full) e_err = 1'b1;
                if (cmpl_valid && in_q) m_done[cmpl_idx] = 1'b1;
                if (retire) begin
                    automatic int s = q.pop_front();
                    automatic logic [88:0] e = m_entry[s];
                    e_wr       = e[23] | e[22];
                    e_arch     = m_arch[s];
                    e_phys     = e[17:12];
                    e_free     = e_wr && (rrat_old_phys != 0);
                    e_free_reg = rrat_old_phys;
                    e_st       = e[21];
                    e_count    = e_count + 1;
                end
                if (alloc) begin
                    q.push_back(m_tail);
                    m_entry[m_tail] = alloc_entry;
                    m_arch[m_tail]  = alloc_arch_dst;
                    m_done[m_tail]  = 1'b0;
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        #1;
        if (check_en) begin
            cmp("alloc_idx", 32'(alloc_idx), 32'(m_tail));
            cmp("rob_halt", 32'(rob_halt), 32'(q.size() >= DEPTH - 1));
            cmp("rrat_wr_en", 32'(rrat_wr_en), 32'(e_wr));
            cmp("rrat_arch", 32'(rrat_arch), 32'(e_arch));
            cmp("rrat_phys", 32'(rrat_phys), 32'(e_phys));
            cmp("rob_free", 32'(rob_free), 32'(e_free));
            cmp("rob_free_reg", 32'(rob_free_reg), 32'(e_free_reg));
            cmp("st_commit", 32'(st_commit), 32'(e_st));
            cmp("retire_count", retire_count, e_count);
            cmp("err_overflow", 32'(err_overflow), 32'(e_err));
            if (rrat_wr_en === 1'b1) phys_log.push_back(rrat_phys);
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic idle();
        RESET = 0; STALL = 0; FLUSH = 0; alloc_valid = 0; cmpl_valid = 0;
    endtask

    task automatic do_reset();
        idle(); RESET = 1; tick(); tick(); RESET = 0;
    endtask

    function automatic logic [88:0] mk(input logic [6:0] ctrl, input logic [5:0] mapc);
        return {$urandom(), $urandom(), ctrl, mapc, 6'($urandom()), 6'($urandom())};
    endfunction

    task automatic alloc(input logic [6:0] ctrl, input logic [5:0] mapc, input logic [4:0] arch);
        alloc_valid = 1; alloc_entry = mk(ctrl, mapc); alloc_arch_dst = arch;
        tick(); alloc_valid = 0;
    endtask

    task automatic complete(input int idx);
        cmpl_valid = 1; cmpl_idx = IDX_W'(idx); tick(); cmpl_valid = 0;
    endtask

    localparam logic [6:0] C_REG   = 7'b0100000;
    localparam logic [6:0] C_STORE = 7'b0001000;

    initial begin
        idle(); rrat_old_phys = 0; alloc_entry = '0; alloc_arch_dst = 0; cmpl_idx = 0;
        RESET = 1; tick(); check_en = 1; tick(); RESET = 0;
        cmp("reset_count", retire_count, 32'd0);
        cmp("reset_halt", 32'(rob_halt), 32'd0);

        // 1: three reg-writes retire in order despite reverse completion
        phys_log.delete();
        alloc(C_REG, 6'd33, 5'd8); alloc(C_REG, 6'd34, 5'd9); alloc(C_REG, 6'd35, 5'd10);
        complete(2); complete(1); complete(0);
        repeat (5) tick();
        cmp("t1_count", retire_count, 32'd3);
        cmp("t1_nret", 32'(phys_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < phys_log.size(); i++)
            cmp("t1_phys", 32'(phys_log[i]), 32'(33 + i));
        cmp("t1_arch", 32'(rrat_arch), 32'd10);

        // 2: fill, halt at 15, overflow on 17th
        do_reset();
        for (int i = 0; i < 14; i++) alloc(C_REG, 6'(i + 1), 5'(i));
        cmp("t2_halt14", 32'(rob_halt), 32'd0);
        alloc(C_REG, 6'd20, 5'd1);
        cmp("t2_halt15", 32'(rob_halt), 32'd1);
        alloc(C_REG, 6'd21, 5'd2);
        cmp("t2_err_before", 32'(err_overflow), 32'd0);
        alloc(C_REG, 6'd22, 5'd3);
        cmp("t2_err", 32'(err_overflow), 32'd1);
        cmp("t2_tail", 32'(alloc_idx), 32'd0);

        // 3: free-list return suppressed for phys 0
        do_reset();
        alloc(C_REG, 6'd40, 5'd4); alloc(C_REG, 6'd41, 5'd5);
        rrat_old_phys = 0; complete(0); tick();
        cmp("t3_wr", 32'(rrat_wr_en), 32'd1);
        cmp("t3_free0", 32'(rob_free), 32'd0);
        rrat_old_phys = 12; complete(1); tick();
        cmp("t3_free12", 32'(rob_free), 32'd1);
        cmp("t3_freereg", 32'(rob_free_reg), 32'd12);

        // 4: store commit
        alloc(C_STORE, 6'd50, 5'd6); complete(2); tick();
        cmp("t4_st", 32'(st_commit), 32'd1);
        cmp("t4_wr", 32'(rrat_wr_en), 32'd0);
        cmp("t4_free", 32'(rob_free), 32'd0);

        // 5: 20 alloc/retire pairs wrap the pointers
        do_reset();
        for (int i = 0; i < 20; i++) begin
            alloc(C_REG, 6'(i + 1), 5'(i)); complete(i % DEPTH); tick();
        end
        cmp("t5_tail", 32'(alloc_idx), 32'd4);
        cmp("t5_count", retire_count, 32'd20);

        // 6: flush beats alloc and retire; stall holds a done head
        alloc(C_REG, 6'd60, 5'd7); alloc(C_REG, 6'd61, 5'd8); complete(4);
        alloc_valid = 1; alloc_entry = mk(C_REG, 6'd62); FLUSH = 1; tick();
        alloc_valid = 0; FLUSH = 0; tick();
        cmp("t6_wr", 32'(rrat_wr_en), 32'd0);
        cmp("t6_count", retire_count, 32'd20);
        cmp("t6_tail", 32'(alloc_idx), 32'd0);
        alloc(C_REG, 6'd63, 5'd9); complete(0);
        STALL = 1;
        repeat (3) begin tick(); cmp("t6_stall", retire_count, 32'd20); end
        STALL = 0; tick();
        cmp("t6_resume", retire_count, 32'd21);

        // random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            RESET = ($urandom_range(0, 999) < 2);
            FLUSH = ($urandom_range(0, 99) == 0);
            STALL = ($urandom_range(0, 9) == 0);
            alloc_valid = ($urandom_range(0, 9) < 6);
            alloc_entry = {$urandom(), $urandom(), 7'($urandom()), 6'($urandom()), 12'($urandom())};
            alloc_arch_dst = 5'($urandom());
            cmpl_valid = ($urandom_range(0, 9) < 7);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                cmpl_idx = IDX_W'(q[$urandom_range(0, q.size() - 1)]);
            else
                cmpl_idx = IDX_W'($urandom());
            rrat_old_phys = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom());
            tick();
        end
        idle(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
